// File: rtl/fb_fill_arbiter_pkg.sv
// Shared definitions for the frame-buffer fill arbiter: FSM states,
// register-block offsets and bit positions used by the bus decode.
package fb_fill_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam logic [7:0] REG_X0   = 8'd0;
  localparam logic [7:0] REG_Y0   = 8'd1;
  localparam logic [7:0] REG_X1   = 8'd2;
  localparam logic [7:0] REG_Y1   = 8'd3;
  localparam logic [7:0] REG_CTRL = 8'd4;

  localparam int unsigned CTRL_COLOUR = 0;
  localparam int unsigned CTRL_ABORT  = 7;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_ERR  = 1;

  function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/fb_fill_arbiter_fill_scanner.sv
// Rectangle scanner: latches ordered, screen-clamped bounds on load and walks
// cx/cy in raster order, one pixel per advance.
module fb_fill_arbiter_fill_scanner
  import fb_fill_arbiter_pkg::*;
#(
  parameter int unsigned ScreenWidth  = 160,
  parameter int unsigned ScreenHeight = 120
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        load,
  input  logic        advance,
  input  logic [7:0]  x0,
  input  logic [7:0]  y0,
  input  logic [7:0]  x1,
  input  logic [7:0]  y1,
  output logic [14:0] addr,
  output logic        last
);

  localparam logic [7:0] XLim = 8'(ScreenWidth - 1);
  localparam logic [7:0] YLim = 8'(ScreenHeight - 1);

  logic [7:0] xlo, xhi;
  logic [6:0] ylo, yhi;
  logic [7:0] xmin_q, xmax_q, cx_q;
  logic [6:0] ymax_q, cy_q;

  always_comb begin
    xlo = clamp8((x0 < x1) ? x0 : x1, XLim);
    xhi = clamp8((x0 < x1) ? x1 : x0, XLim);
    ylo = 7'(clamp8((y0 < y1) ? y0 : y1, YLim));
    yhi = 7'(clamp8((y0 < y1) ? y1 : y0, YLim));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      xmin_q <= '0;
      xmax_q <= '0;
      ymax_q <= '0;
      cx_q   <= '0;
      cy_q   <= '0;
    end else if (load) begin
      xmin_q <= xlo;
      xmax_q <= xhi;
      ymax_q <= yhi;
      cx_q   <= xlo;
      cy_q   <= ylo;
    end else if (advance) begin
      if (cx_q == xmax_q) begin
        cx_q <= xmin_q;
        cy_q <= cy_q + 7'd1;
      end else begin
        cx_q <= cx_q + 8'd1;
      end
    end
  end

  assign addr = {cy_q, cx_q};
  assign last = (cx_q == xmax_q) && (cy_q == ymax_q);

endmodule

// File: rtl/fb_fill_arbiter.sv
// Frame-buffer write-port controller: arbitrates a single-pixel requester
// against a bus-programmed rectangle-fill engine.
module fb_fill_arbiter
  import fb_fill_arbiter_pkg::*;
#(
  parameter logic [7:0]  FillBaseAddress = 8'hC0,
  parameter int unsigned ScreenWidth     = 160,
  parameter int unsigned ScreenHeight    = 120
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  BUS_ADDR,
  inout  wire  [7:0]  BUS_DATA,
  input  logic        BUS_WE,
  input  logic        PIX_VALID,
  output logic        PIX_READY,
  input  logic [7:0]  PIX_X,
  input  logic [6:0]  PIX_Y,
  input  logic        PIX_DATA,
  output logic [14:0] FB_ADDR,
  output logic        FB_DATA,
  output logic        FB_WE,
  output logic        FILL_DONE
);

  state_t      state_q, state_d;
  logic [7:0]  x0_q, y0_q, x1_q, y1_q;
  logic        colour_q, err_q, pix_last_q;
  logic [7:0]  off;
  logic        in_range, wr_hit, start_cmd, abort_cmd;
  logic        busy, pix_grant, fill_grant, scan_load, done_d;
  logic [14:0] scan_addr;
  logic        scan_last;
  logic        rd_en_q;
  logic [7:0]  rd_data_q, rd_data_d;

  assign off       = BUS_ADDR - FillBaseAddress;
  assign in_range  = (BUS_ADDR >= FillBaseAddress) && (off <= REG_CTRL);
  assign wr_hit    = BUS_WE && in_range;
  assign start_cmd = wr_hit && (off == REG_CTRL) && !BUS_DATA[CTRL_ABORT];
  assign abort_cmd = wr_hit && (off == REG_CTRL) &&  BUS_DATA[CTRL_ABORT];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_cmd) state_d = FILL;
      FILL: if (abort_cmd || (fill_grant && scan_last)) state_d = IDLE;
    endcase
  end

  // Under contention the pixel port wins unless it took the previous grant.
  always_comb begin
    busy       = (state_q == FILL);
    pix_grant  = RESET && PIX_VALID && (!busy || !pix_last_q);
    fill_grant = busy && !pix_grant;
    scan_load  = !busy && start_cmd;
    done_d     = fill_grant && scan_last && !abort_cmd;
  end

  assign PIX_READY = pix_grant;

  fb_fill_arbiter_fill_scanner #(
    .ScreenWidth (ScreenWidth),
    .ScreenHeight(ScreenHeight)
  ) u_fill_scanner (
    .CLK    (CLK),
    .RESET  (RESET),
    .load   (scan_load),
    .advance(fill_grant),
    .x0     (x0_q),
    .y0     (y0_q),
    .x1     (x1_q),
    .y1     (y1_q),
    .addr   (scan_addr),
    .last   (scan_last)
  );

  always_comb begin
    rd_data_d = '0;
    case (off)
      REG_X0:   rd_data_d = x0_q;
      REG_Y0:   rd_data_d = y0_q;
      REG_X1:   rd_data_d = x1_q;
      REG_Y1:   rd_data_d = y1_q;
      REG_CTRL: begin
        rd_data_d[STAT_BUSY] = busy;
        rd_data_d[STAT_ERR]  = err_q;
      end
      default:  rd_data_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      colour_q   <= 1'b0;
      err_q      <= 1'b0;
      pix_last_q <= 1'b0;
      FB_WE      <= 1'b0;
      FB_ADDR    <= '0;
      FB_DATA    <= 1'b0;
      FILL_DONE  <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (wr_hit) begin
        case (off)
          REG_X0:  x0_q <= BUS_DATA;
          REG_Y0:  y0_q <= BUS_DATA;
          REG_X1:  x1_q <= BUS_DATA;
          REG_Y1:  y1_q <= BUS_DATA;
          default: ;
        endcase
      end
      if (scan_load) begin
        colour_q <= BUS_DATA[CTRL_COLOUR];
        err_q    <= 1'b0;
      end else if (busy && start_cmd) begin
        err_q <= 1'b1;
      end
      if (pix_grant || fill_grant) pix_last_q <= pix_grant;
      FB_WE     <= pix_grant || fill_grant;
      FILL_DONE <= done_d;
      if (pix_grant) begin
        FB_ADDR <= {PIX_Y, PIX_X};
        FB_DATA <= PIX_DATA;
      end else if (fill_grant) begin
        FB_ADDR <= scan_addr;
        FB_DATA <= colour_q;
      end
      rd_en_q   <= !BUS_WE && in_range;
      rd_data_q <= rd_data_d;
    end
  end

  assign BUS_DATA = rd_en_q ? rd_data_q : 'z;

endmodule

// File: doc/fb_fill_arbiter.md
Name: fb_fill_arbiter

Overview:
Frame-buffer write controller in front of the VGA frame buffer's A port (15-bit address {Y[6:0],X[7:0]}, 1-bit pixel).
- Shares the single write port between two requesters: a single-pixel requester (valid/ready) and an internal rectangle-fill engine.
- The fill engine is configured and started by the processor over the 8-bit memory-mapped bus.
- Lets software clear the screen or draw boxes without issuing one bus write per pixel.

Parameters:
FillBaseAddress, 8'hC0, first bus address of the 5-register block (base+0..base+4).
ScreenWidth, 160, pixels per line; X coordinates clamp to ScreenWidth-1.
ScreenHeight, 120, lines per frame; Y coordinates clamp to ScreenHeight-1.

Ports:
CLK  input  1  system clock, all logic on rising edge.
RESET  input  1  asynchronous, active-low reset.
BUS_ADDR  input  8  processor bus address.
BUS_DATA  inout  8  processor bus data; driven only during a register read.
BUS_WE  input  1  processor bus write strobe.
PIX_VALID  input  1  single-pixel write request.
PIX_READY  output  1  grant for PIX_VALID, combinational.
PIX_X  input  8  pixel X.
PIX_Y  input  7  pixel Y.
PIX_DATA  input  1  pixel value.
FB_ADDR  output  15  frame-buffer write address {Y,X}.
FB_DATA  output  1  frame-buffer write data.
FB_WE  output  1  frame-buffer write enable.
FILL_DONE  output  1  one-cycle pulse when a fill completes normally.

Behaviour:
Reset (RESET=0, asynchronous):
- FSM goes to IDLE; all registers zero.
- FB_WE=0, FB_ADDR=0, FB_DATA=0, FILL_DONE=0, PIX_READY=0, BUS_DATA=Z.
- A fill in progress is lost without a FILL_DONE pulse.

Registers, written when BUS_WE=1:
- base+0 X0, base+1 Y0, base+2 X1, base+3 Y1.
- base+4 CTRL: bit0=colour, bit7=abort; any write to CTRL with bit7=0 is a start command.

Read path (BUS_WE=0):
- The block drives BUS_DATA when BUS_ADDR is in base..base+4. Drive enable and data are both registered, so there is 1-cycle read latency.
- Reading base+0..3 returns the stored coordinate.
- Reading base+4 returns {6'b0, err, busy}.

FSM:
- IDLE -> FILL on a start.
  - Latch xmin=min(X0,X1), xmax=max(X0,X1), ymin, ymax the same way, each clamped to the screen limits.
  - Latch colour; cx=xmin, cy=ymin; clear err.
- FILL: each cycle the engine is granted, cx increments; at cx==xmax, cx wraps to xmin and cy increments.
- Grant at cx==xmax and cy==ymax -> IDLE, with FILL_DONE pulsed the next cycle, aligned with the final FB_WE.
- Abort write in FILL -> IDLE next cycle; no FILL_DONE; pixels already written stay. Abort in IDLE is a no-op.
- Start while busy is ignored and sets sticky err.
- Coordinate writes while busy update the registers only; they affect the next fill, not the running one.

busy = (state==FILL).

Arbitration, evaluated each cycle:
- Only one requester active -> grant it.
- Both active -> alternate using a last-grant flag, initialised to favour the pixel port after reset.
- Worst-case pixel wait is 1 cycle; fill throughput is at least 1 pixel per 2 cycles under contention.
- PIX_READY = grant to the pixel port. A transfer occurs when PIX_VALID && PIX_READY.

Output timing:
- FB_ADDR/FB_DATA/FB_WE are registered: a grant in cycle N produces the write in cycle N+1.
- FB_WE=0 when nothing is granted. FB_ADDR/FB_DATA hold their last value.
- Single-pixel requests are not clamped; the caller supplies legal coordinates.
- A 1x1 fill (X0==X1, Y0==Y1) writes exactly one pixel.

Decomposition:
- Shared package holds: FSM state encoding (IDLE, FILL), register offsets (0..4), CTRL bit positions (COLOUR=0, ABORT=7), status bit positions (BUSY=0, ERR=1).
- One sub-module, fill_scanner: holds the latched bounds and cx/cy counters, and exposes addr, last and advance. The arbiter and bus decode stay in the top module.

Test Plan:
- Fill X0=2,Y0=3,X1=4,Y1=4, CTRL=1, no pixel traffic -> 6 FB_WE pulses, addresses {3,2},{3,3},{3,4},{4,2},{4,3},{4,4}, data 1, FILL_DONE with the 6th, status reads 0.
- Reversed/out-of-range coordinates X0=200,X1=158,Y0=119,Y1=130 -> writes X 158..159, Y 119 only (2 writes).
- PIX_VALID held during a 4-pixel fill -> grants alternate pixel/fill; fill finishes within 8 cycles; no cycle has two writes.
- Start while busy -> status reads 0x03, current fill unaffected; the next start reads busy with err cleared.
- Abort mid-fill after 3 writes -> FB_WE stops after at most 1 further write, no FILL_DONE, status 0x00.
- RESET asserted mid-fill (asynchronously, between edges) -> FB_WE=0 and busy=0 immediately; after release, the block is idle until a new start.
